reg_file: RTL and testbench
===========================

// Module: reg_file
// PURPOSE
//   MIPS general-purpose register file. Holds 2**ADDR_W registers of DATA_W bits.
//   Sits directly downstream of the write-register-select mux (rt/rd/$31), which drives wa.
//   Two combinational read ports feed the ALU operand path; one synchronous write port
//   takes the writeback result. A debug read port exposes registers to the testbench.
// PARAMETERS
//   DATA_W   32            register and data width in bits
//   ADDR_W   5             register address width; depth = 2**ADDR_W
//   BYPASS   1             1: same-cycle write-to-read forwarding; 0: read returns stored value
//   GP_INIT  32'h00001800  reset value of register 28 ($gp)
//   SP_INIT  32'h00002ffc  reset value of register 29 ($sp)
// PORTS
//   clk       in   1       clock, rising-edge
//   rst_n     in   1       synchronous reset, active-low
//   ra1       in   ADDR_W  read address, port 1 (rs)
//   ra2       in   ADDR_W  read address, port 2 (rt)
//   rd1       out  DATA_W  read data, port 1
//   rd2       out  DATA_W  read data, port 2
//   we        in   1       write enable
//   wa        in   ADDR_W  write address (from write-register-select mux)
//   wd        in   DATA_W  write data
//   dbg_addr  in   ADDR_W  debug read address
//   dbg_data  out  DATA_W  debug read data, stored value only, never bypassed
// BEHAVIOUR
//   - One clock (clk). Reset is synchronous and active-low: sampled only on rising clk.
//   - Reset: on a rising clk edge with rst_n=0, all registers clear to 0.
//     Exceptions: reg 28 loads GP_INIT and reg 29 loads SP_INIT (truncated/zero-extended to DATA_W).
//   - Reset has priority over write: a write in a reset cycle is dropped.
//   - Write: on a rising clk edge with rst_n=1, we=1 and wa!=0, reg[wa] <= wd.
//     Written value is visible in storage from the next cycle.
//   - Register 0: hardwired to 0. Writes to wa=0 are discarded.
//     rd1, rd2 and dbg_data return 0 for address 0 under all conditions, bypass included.
//   - Reads: rd1, rd2 and dbg_data are combinational from their addresses (zero-cycle latency).
//     Outputs have no reset value of their own. After reset they reflect the reset contents:
//     0, GP_INIT for reg 28, SP_INIT for reg 29.
//   - Bypass (BYPASS=1): if we=1, wa!=0, rst_n=1 and raN==wa, then rdN=wd in the same cycle.
//     Applies to each port independently; both ports may bypass at once.
//     With rst_n=0 there is no bypass and rd shows stored contents.
//   - BYPASS=0: rdN always shows stored contents; a same-address read sees the old value
//     until the edge.
//   - ra1==ra2 is legal; both ports return identical data.
//   - Reset mid-operation: contents revert at the reset edge. No pending state exists.
// TESTING
//   1. Reset: rst_n=0 for 1 edge -> dbg_data reads 0 for regs 1..27, 30, 31;
//      reg 28 = 0x00001800, reg 29 = 0x00002ffc.
//   2. Write/readback: we=1, wa=5, wd=0xDEADBEEF, edge.
//      Then ra1=5 -> rd1=0xDEADBEEF; ra2=6 -> rd2=0.
//   3. Zero reg: we=1, wa=0, wd=0xFFFFFFFF, edge -> ra1=0 gives rd1=0 before and after the edge.
//      dbg_data(0)=0.
//   4. Bypass: BYPASS=1, reg 7=0x11; drive we=1, wa=7, wd=0x22, ra1=ra2=7 before the edge
//      -> rd1=rd2=0x22 combinationally; dbg_data(7)=0x11 until the edge, then 0x22.
//      With BYPASS=0: rd1=0x11 until the edge.
//   5. Reset priority: rst_n=0, we=1, wa=29, wd=0x1234, edge -> reg 29=0x00002ffc.
//      rd on 29 during that cycle shows the stored value, not 0x1234.
//   6. Back-to-back: writes to regs 31, 1, 31 on consecutive edges (0xA, 0xB, 0xC)
//      -> reg 31=0xC, reg 1=0xB; no other register changes.

Source files
------------

// File: rtl/reg_file.sv
// MIPS general-purpose register file: two combinational read ports with optional
// write-to-read forwarding, one synchronous write port, and an unbypassed debug port.

module reg_file_rd_port #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0] regs,
    input  logic [ADDR_W-1:0]                  ra,
    input  logic                               byp_vld,
    input  logic [ADDR_W-1:0]                  wa,
    input  logic [DATA_W-1:0]                  wd,
    output logic [DATA_W-1:0]                  rd
);
    always_comb begin
        rd = regs[ra];
        if (byp_vld && (ra == wa)) rd = wd;
        // $zero wins over everything, including forwarding
        if (ra == '0) rd = '0;
    end
endmodule

module reg_file #(
    parameter int          DATA_W  = 32,
    parameter int          ADDR_W  = 5,
    parameter int          BYPASS  = 1,
    parameter logic [31:0] GP_INIT = 32'h0000_1800,
    parameter logic [31:0] SP_INIT = 32'h0000_2ffc
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);
    localparam int DEPTH     = 1 << ADDR_W;
    localparam int NUM_PORTS = 3;  // rd1, rd2, debug

    typedef struct packed {
        logic              en;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

    wr_req_t                                 wr;
    logic [DEPTH-1:0][DATA_W-1:0]            regs;
    logic [NUM_PORTS-1:0][ADDR_W-1:0]        ra_vec;
    logic [NUM_PORTS-1:0][DATA_W-1:0]        rd_vec;

    function automatic logic [DATA_W-1:0] rst_val(input int idx);
        if (idx == 28) return DATA_W'(GP_INIT);
        if (idx == 29) return DATA_W'(SP_INIT);
        return '0;
    endfunction

    // A write is only real when not in reset and not aimed at $zero; the same
    // qualifier gates forwarding so a dropped write is never bypassed.
    always_comb begin
        wr.en   = we && rst_n && (wa != '0);
        wr.addr = wa;
        wr.data = wd;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= rst_val(i);
        end else if (wr.en) begin
            regs[wr.addr] <= wr.data;
        end
    end

    assign ra_vec = {dbg_addr, ra2, ra1};

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rd
        // Debug port always shows stored contents
        localparam bit BYP = (p < 2) && (BYPASS != 0);
        reg_file_rd_port #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_rd (
            .regs    (regs),
            .ra      (ra_vec[p]),
            .byp_vld (BYP && wr.en),
            .wa      (wr.addr),
            .wd      (wr.data),
            .rd      (rd_vec[p])
        );
    end

    assign rd1      = rd_vec[0];
    assign rd2      = rd_vec[1];
    assign dbg_data = rd_vec[2];
endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: a bypassing and a non-bypassing instance share stimulus;
// expectations are queued as inputs are driven and drained against the outputs before the edge.

module tb_reg_file;
    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n, we;
    logic [AW-1:0] ra1, ra2, wa, dbg_addr;
    logic [DW-1:0] wd;
    logic [DW-1:0] rd1, rd2, dbg_data;
    logic [DW-1:0] nb_rd1, nb_rd2, nb_dbg;

    always #5 clk = ~clk;

    reg_file #(.BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .we(we), .wa(wa), .wd(wd), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    reg_file #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2), .rd1(nb_rd1), .rd2(nb_rd2),
        .we(we), .wa(wa), .wd(wd), .dbg_addr(dbg_addr), .dbg_data(nb_dbg)
    );

    typedef struct packed {
        logic [95:0]   tag;
        logic [2:0]    src;  // 0 rd1, 1 rd2, 2 dbg, 3..5 same on the non-bypass instance
        logic [DW-1:0] exp;
    } sb_t;

    sb_t           sb_q[$];
    int            n_vec = 0;
    int            n_mis = 0;
    logic [DW-1:0] mem[32];

    task automatic chk(input logic [95:0] tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %0s: got %h want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic push(input logic [95:0] tag, input logic [2:0] src, input logic [DW-1:0] exp);
        sb_t e;
        e.tag = tag; e.src = src; e.exp = exp;
        sb_q.push_back(e);
    endtask

    function automatic logic [DW-1:0] observe(input logic [2:0] src);
        case (src)
            3'd0:    return rd1;
            3'd1:    return rd2;
            3'd2:    return dbg_data;
            3'd3:    return nb_rd1;
            3'd4:    return nb_rd2;
            default: return nb_dbg;
        endcase
    endfunction

    task automatic drain();
        sb_t e;
        #2;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk(e.tag, observe(e.src), e.exp);
        end
    endtask

    function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a, input bit byp);
        if (a == 0) return '0;
        if (byp && rst_n && we && wa != 0 && a == wa) return wd;
        return mem[a];
    endfunction

    task automatic push_model(input logic [95:0] tag);
        push(tag, 3'd0, model_rd(ra1, 1'b1));
        push(tag, 3'd1, model_rd(ra2, 1'b1));
        push(tag, 3'd2, model_rd(dbg_addr, 1'b0));
        push(tag, 3'd3, model_rd(ra1, 1'b0));
        push(tag, 3'd4, model_rd(ra2, 1'b0));
        push(tag, 3'd5, model_rd(dbg_addr, 1'b0));
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mem[i] = '0;
        mem[28] = 32'h0000_1800;
        mem[29] = 32'h0000_2ffc;
    endtask

    // One rising edge, mirrored into the model, ending on the falling edge for new stimulus
    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else if (we && wa != 0) mem[wa] = wd;
        @(negedge clk);
    endtask

    initial begin
        logic [DW-1:0] e;
        rst_n = 1'b0; we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0; dbg_addr = '0;
        for (int i = 0; i < 32; i++) mem[i] = '0;
        @(negedge clk);
        tick();
        rst_n = 1'b1;

        // reset contents
        for (int a = 0; a < 32; a++) begin
            dbg_addr = AW'(a); ra1 = AW'(a); ra2 = AW'(31 - a);
            e = (a == 28) ? 32'h0000_1800 : (a == 29) ? 32'h0000_2ffc : 32'h0;
            push("rst_dbg", 3'd2, e);
            push("rst_rd1", 3'd0, e);
            drain();
        end

        // write / readback
        we = 1'b1; wa = 5'd5; wd = 32'hDEAD_BEEF;
        tick();
        we = 1'b0; ra1 = 5'd5; ra2 = 5'd6; dbg_addr = 5'd5;
        push("wr_rd1", 3'd0, 32'hDEAD_BEEF);
        push("wr_rd2", 3'd1, 32'h0);
        push("wr_dbg", 3'd2, 32'hDEAD_BEEF);
        push("wr_nb_rd1", 3'd3, 32'hDEAD_BEEF);
        drain();

        // writes to $zero are discarded and never forwarded
        we = 1'b1; wa = 5'd0; wd = 32'hFFFF_FFFF; ra1 = 5'd0; ra2 = 5'd0; dbg_addr = 5'd0;
        push("z_pre_rd1", 3'd0, 32'h0);
        push("z_pre_rd2", 3'd1, 32'h0);
        push("z_pre_nb", 3'd3, 32'h0);
        drain();
        tick();
        push("z_post_rd1", 3'd0, 32'h0);
        push("z_post_dbg", 3'd2, 32'h0);
        drain();

        // bypass vs. stored value
        wa = 5'd7; wd = 32'h11;
        tick();
        wd = 32'h22; ra1 = 5'd7; ra2 = 5'd7; dbg_addr = 5'd7;
        push("byp_rd1", 3'd0, 32'h22);
        push("byp_rd2", 3'd1, 32'h22);
        push("byp_dbg", 3'd2, 32'h11);
        push("nb_rd1_old", 3'd3, 32'h11);
        push("nb_rd2_old", 3'd4, 32'h11);
        push("nb_dbg_old", 3'd5, 32'h11);
        drain();
        tick();
        we = 1'b0;
        push("byp_dbg_new", 3'd2, 32'h22);
        push("nb_rd1_new", 3'd3, 32'h22);
        push("byp_rd1_new", 3'd0, 32'h22);
        drain();

        // reset beats a simultaneous write, no bypass during reset
        we = 1'b1; wa = 5'd29; wd = 32'h55;
        tick();
        rst_n = 1'b0; wd = 32'h1234; ra1 = 5'd29; ra2 = 5'd29; dbg_addr = 5'd29;
        push("rstw_rd1", 3'd0, 32'h55);
        push("rstw_rd2", 3'd1, 32'h55);
        push("rstw_dbg", 3'd2, 32'h55);
        drain();
        tick();
        rst_n = 1'b1; we = 1'b0;
        push("rstw_sp", 3'd2, 32'h0000_2ffc);
        push("rstw_sp_rd1", 3'd0, 32'h0000_2ffc);
        drain();
        dbg_addr = 5'd5;  push("rst_r5", 3'd2, 32'h0);  drain();
        dbg_addr = 5'd7;  push("rst_r7", 3'd2, 32'h0);  drain();

        // back-to-back writes
        we = 1'b1; wa = 5'd31; wd = 32'hA; tick();
        wa = 5'd1; wd = 32'hB; tick();
        wa = 5'd31; wd = 32'hC; tick();
        we = 1'b0;
        dbg_addr = 5'd31; push("b2b_r31", 3'd2, 32'hC); drain();
        dbg_addr = 5'd1;  push("b2b_r1", 3'd2, 32'hB);  drain();
        for (int a = 0; a < 32; a++) begin
            dbg_addr = AW'(a); ra1 = AW'(a); ra2 = AW'(a ^ 1);
            push_model("b2b_sweep");
            drain();
        end

        // random traffic with occasional reset
        for (int n = 0; n < 200; n++) begin
            rst_n = ($urandom_range(0, 24) != 0);
            we = 1'($urandom_range(0, 1));
            wa = AW'($urandom);
            wd = $urandom;
            ra1 = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom);
            ra2 = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom);
            dbg_addr = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom);
            push_model("rand");
            drain();
            tick();
        end
        rst_n = 1'b1; we = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
